// File: rtl/dlsc_cpu1_exwb_pkg.sv
// dlsc_cpu1_exwb_pkg
//   Shared definitions for the cpu1 execute-to-writeback stage.
//   - state_t : trap FSM encoding (ST_RUN, ST_TRAP)
//   - DEF_DATA / DEF_REGB : default entry field widths (result, register index)
//   - R0_IDX : index of the hardwired-zero register, shared with the decoder
//              and the ALU operand mux
package dlsc_cpu1_exwb_pkg;

   localparam int unsigned DEF_DATA = 32;
   localparam int unsigned DEF_REGB = 5;
   localparam int unsigned R0_IDX   = 0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } state_t;

endpackage

// File: rtl/dlsc_cpu1_exwb_skid.sv
// dlsc_cpu1_exwb_skid
//   Two-entry FIFO holding pending register-file writes. The head entry drives
//   the write port and only changes on a pop or on a push into an empty
//   buffer, so head_* stay stable while a write is stalled.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     flush               discard all entries
//     push, push_dest/data  enqueue an entry (ignored when full without pop)
//     pop                 dequeue the head (ignored when empty)
//     count               occupancy 0..2
//     head_dest/data      oldest entry (write port)
//     tail_dest/data      second entry, valid only when count==2
module dlsc_cpu1_exwb_skid
   import dlsc_cpu1_exwb_pkg::*;
#(
   parameter int DATA = DEF_DATA,
   parameter int REGB = DEF_REGB
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            push,
   input  logic [REGB-1:0] push_dest,
   input  logic [DATA-1:0] push_data,
   input  logic            pop,
   output logic [1:0]      count,
   output logic [REGB-1:0] head_dest,
   output logic [DATA-1:0] head_data,
   output logic [REGB-1:0] tail_dest,
   output logic [DATA-1:0] tail_data
);

   logic [1:0]      count_q, count_d;
   logic [REGB-1:0] head_dest_q, head_dest_d, tail_dest_q, tail_dest_d;
   logic [DATA-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic            do_push, do_pop;

   assign do_pop  = pop & (count_q != 2'd0);
   assign do_push = push & ((count_q != 2'd2) | do_pop);

   // Pop first (shift tail into head), then place the push into the first
   // free slot of the post-pop occupancy; this covers push+pop at count 1
   // (new entry becomes head) and at count 2 (new entry becomes tail).
   always_comb begin
      count_d     = count_q;
      head_dest_d = head_dest_q;
      head_data_d = head_data_q;
      tail_dest_d = tail_dest_q;
      tail_data_d = tail_data_q;
      if (do_pop) begin
         head_dest_d = tail_dest_q;
         head_data_d = tail_data_q;
         count_d     = count_d - 2'd1;
      end
      if (do_push) begin
         if (count_d == 2'd0) begin
            head_dest_d = push_dest;
            head_data_d = push_data;
         end else begin
            tail_dest_d = push_dest;
            tail_data_d = push_data;
         end
         count_d = count_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         head_dest_q <= '0;
         head_data_q <= '0;
         tail_dest_q <= '0;
         tail_data_q <= '0;
      end else if (flush) begin
         count_q     <= '0;
         head_dest_q <= '0;
         head_data_q <= '0;
         tail_dest_q <= '0;
         tail_data_q <= '0;
      end else begin
         count_q     <= count_d;
         head_dest_q <= head_dest_d;
         head_data_q <= head_data_d;
         tail_dest_q <= tail_dest_d;
         tail_data_q <= tail_data_d;
      end
   end

   assign count     = count_q;
   assign head_dest = head_dest_q;
   assign head_data = head_data_q;
   assign tail_dest = tail_dest_q;
   assign tail_data = tail_data_q;

endmodule

// File: rtl/dlsc_cpu1_exwb.sv
// dlsc_cpu1_exwb
//   Execute-to-writeback stage of the cpu1 core. Buffers ALU results in a
//   2-entry skid FIFO and presents them to the register-file write port.
//   Signed overflow raises a one-cycle trap pulse and stops acceptance until
//   flush. Optional forwarding lookup enabled by macro DLSC_CPU1_EXWB_FWD_EN;
//   without it fwd_hit/fwd_data are tied to 0.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     flush             drop buffered entries, clear trap state
//     in_valid/in_ready upstream handshake (in_ready registered)
//     in_d, in_overflow, in_trap_en, in_we, in_dest   ALU entry fields
//     wb_valid/wb_ready, wb_dest, wb_data             register write port
//     trap, trap_dest   overflow trap pulse, trapping destination
//     fwd_addr, fwd_hit, fwd_data                     forwarding lookup
//     count             buffer occupancy
module dlsc_cpu1_exwb
   import dlsc_cpu1_exwb_pkg::*;
#(
   parameter int DATA = 32,
   parameter int REGB = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DATA-1:0] in_d,
   input  logic            in_overflow,
   input  logic            in_trap_en,
   input  logic            in_we,
   input  logic [REGB-1:0] in_dest,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [REGB-1:0] wb_dest,
   output logic [DATA-1:0] wb_data,
   output logic            trap,
   output logic [REGB-1:0] trap_dest,
   input  logic [REGB-1:0] fwd_addr,
   output logic            fwd_hit,
   output logic [DATA-1:0] fwd_data,
   output logic [1:0]      count
);

   localparam logic [REGB-1:0] R0 = REGB'(R0_IDX);

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            trap_q;
   logic [REGB-1:0] trap_dest_q;
   logic            accept, trap_hit, push, pop;
   logic [1:0]      count_w, count_d;
   logic [REGB-1:0] tail_dest;
   logic [DATA-1:0] tail_data;

   dlsc_cpu1_exwb_skid #(
      .DATA (DATA),
      .REGB (REGB)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_dest (in_dest),
      .push_data (in_d),
      .pop       (pop),
      .count     (count_w),
      .head_dest (wb_dest),
      .head_data (wb_data),
      .tail_dest (tail_dest),
      .tail_data (tail_data)
   );

   always_comb begin
      accept   = in_valid & in_ready_q & ~flush;
      trap_hit = accept & in_trap_en & in_overflow;
      push     = accept & in_we & (in_dest != R0) & ~trap_hit;
      pop      = (count_w != 2'd0) & wb_ready & ~flush;

      state_d = state_q;
      case (state_q)
         ST_RUN:  if (trap_hit) state_d = ST_TRAP;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_RUN;
      endcase
      if (flush) state_d = ST_RUN;

      count_d = flush ? 2'd0 : (count_w + {1'b0, push} - {1'b0, pop});

      // A pop from a full buffer frees its slot one cycle late: in_ready stays
      // low for the cycle after count==2 regardless of the pop.
      in_ready_d = (count_d < 2'd2) & ((count_w != 2'd2) | flush) &
                   (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         in_ready_q  <= 1'b0;
         trap_q      <= 1'b0;
         trap_dest_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         trap_q     <= trap_hit;
         if (flush)
            trap_dest_q <= '0;
         else if (trap_hit)
            trap_dest_q <= in_dest;
      end
   end

   assign in_ready  = in_ready_q;
   assign trap      = trap_q;
   assign trap_dest = trap_dest_q;
   assign wb_valid  = (count_w != 2'd0);
   assign count     = count_w;

`ifdef DLSC_CPU1_EXWB_FWD_EN
   logic head_match, tail_match;

   // Tail is the younger entry, so it wins when both match.
   always_comb begin
      head_match = (count_w != 2'd0) & (wb_dest == fwd_addr);
      tail_match = (count_w == 2'd2) & (tail_dest == fwd_addr);
      fwd_hit    = (fwd_addr != R0) & (head_match | tail_match);
      fwd_data   = '0;
      if (fwd_addr != R0) begin
         if (tail_match)
            fwd_data = tail_data;
         else if (head_match)
            fwd_data = wb_data;
      end
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{fwd_addr, tail_dest, tail_data};
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: doc/dlsc_cpu1_exwb.md
# dlsc_cpu1_exwb

Execute-to-writeback stage of the cpu1 core, directly downstream of the ALU. It captures the ALU result, destination register and overflow status into a 2-entry skid buffer, then presents writes to the shared register-file write port with a valid/ready handshake. Signed overflow raises a trap and halts acceptance until flush. The stage also offers an optional forwarding lookup back to the operand mux that feeds the ALU.

## Interface
Parameters:
- DATA, 32: result width; matches the ALU output.
- REGB, 5: register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  kills all buffered entries and clears the trap state.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_d  in  DATA  ALU result (out_d).
- in_overflow  in  1  ALU adder overflow.
- in_trap_en  in  1  signed add/sub; overflow is meaningful.
- in_we  in  1  entry writes a register.
- in_dest  in  REGB  destination register.
- wb_valid  out  1  write request to the register file.
- wb_ready  in  1  write port granted this cycle.
- wb_dest  out  REGB  write address.
- wb_data  out  DATA  write data.
- trap  out  1  one-cycle overflow-trap pulse.
- trap_dest  out  REGB  destination of the trapping entry; held until flush.
- fwd_addr  in  REGB  operand register being looked up.
- fwd_hit  out  1  a pending buffered write targets fwd_addr.
- fwd_data  out  DATA  data of the youngest matching entry.
- count  out  2  occupancy, 0..2.

## Operation
- Accept on in_valid & in_ready.
- The incoming entry is dropped with no buffer slot and no wb request when any of these holds:
  - in_we=0;
  - in_dest=0 (r0 is hardwired);
  - the entry traps.
- An entry traps when in_trap_en & in_overflow:
  - trap pulses for 1 cycle and trap_dest is captured;
  - the state moves RUN→TRAP.
- State machine, RUN and TRAP:
  - RUN: accepts entries normally.
  - TRAP: in_ready=0 and no new accepts. Entries already buffered keep draining to wb, so older writes still retire.
  - flush moves either state to RUN.
- Buffer is a 2-entry FIFO; the head drives wb_*.
  - wb_valid = (count≠0).
  - Pop on wb_valid & wb_ready.
  - wb_dest and wb_data must stay stable while wb_valid & !wb_ready.
- Simultaneous push and pop at count=1: count stays 1, the head becomes the new entry.
- Forwarding: fwd_hit = any valid entry with dest==fwd_addr and fwd_addr≠0. When both entries match, the youngest (tail) supplies fwd_data. The lookup is combinational from the buffer state and does not see the entry being accepted in the same cycle.
- flush takes priority over everything in the same cycle:
  - next cycle count=0, wb_valid=0, state=RUN, trap_dest=0;
  - any accept, pop or trap in the flush cycle is discarded;
  - a trap pulse is suppressed if flush is asserted the same cycle.

## Timing
- Reset values: in_ready=0 during reset and 1 from the first edge after release; count=0; wb_valid=0; wb_dest=0; wb_data=0; trap=0; trap_dest=0; fwd_hit=0; state=RUN.
- Latency: an entry accepted at edge N appears on wb_valid after edge N (1 cycle) when the buffer was empty.
- in_ready is registered: in_ready = (count_next<2) & (state_next==RUN).
  - At count=2 the stage deasserts in_ready even if a pop occurs that cycle. The pop frees a slot that becomes visible the following cycle.
- Throughput: 1 entry/cycle sustained with wb_ready held at 1.
- trap is asserted in the cycle after acceptance of the trapping entry. in_ready=0 from that same cycle.
- rst_n asserted mid-operation: all state clears immediately (asynchronous); no partial write is presented.

## Configuration
- DLSC_CPU1_EXWB_FWD_EN defined: forwarding lookup is implemented as described.
- Not defined: fwd_hit is tied to 0 and fwd_data to 0. The ports remain so the instantiation is unchanged. The core then relies on stall-on-hazard upstream.

## Structure
- Shared package holds:
  - the state encoding (RUN, TRAP);
  - entry field widths;
  - the r0 index constant, shared with the decoder and ALU operand mux.
- One natural sub-module: dlsc_cpu1_exwb_skid. It is the 2-entry FIFO with stable-output guarantee and exposes both entries for the forwarding compare.
- The trap FSM and the forward compare stay in the top module.

## Test plan
- Single write: accept dest=3, d=0x12345678 with wb_ready=1 → the next cycle shows wb_valid=1, wb_dest=3, wb_data=0x12345678; then count=0.
- Backpressure: wb_ready=0 and 3 back-to-back entries (dest 1,2,3) → 2 accepted, in_ready=0, count=2, wb_* held at dest 1. Release wb_ready → writes retire in order 1,2,3.
- r0 and no-write drop: dest=0 with we=1, and dest=5 with we=0 → no wb_valid, count stays 0.
- Overflow trap: entry dest=7, in_trap_en=1, in_overflow=1, after a buffered dest=4 write → trap pulses 1 cycle with trap_dest=7, dest=4 still retires, dest 7 is never written, in_ready=0 until flush, then in_ready=1.
- Forwarding (macro on): buffer dest=9 d=0xA then dest=9 d=0xB, fwd_addr=9 → fwd_hit=1, fwd_data=0xB. With fwd_addr=0 → fwd_hit=0. Macro off → fwd_hit=0 always.
- Flush and async reset: count=2 then flush → next cycle count=0, wb_valid=0. Assert rst_n low mid-stream → all outputs reach reset values without waiting for a clock edge.
